// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared types and glyph table for the 7-segment scan controller
// Purpose: scan FSM state encoding, segment bit positions and the hex glyph
//   table used by seg7_scan_ctrl and seg7_hex_decode.
// Ports: none (package).
package seg7_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    COMMIT = 2'd1,
    BLANK  = 2'd2,
    SHOW   = 2'd3
  } seg7_state_e;

  // Segment bit positions on seg_out.
  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  // Glyphs for 0..F, index 15 is the leftmost element.
  localparam logic [15:0][6:0] HEX_GLYPH = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  function automatic logic [6:0] hex_glyph(input logic [3:0] nibble);
    return HEX_GLYPH[nibble];
  endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// rtl/seg7_hex_decode.sv - combinational hex nibble to 7-segment glyph decoder
// Purpose: maps a 4-bit value to its active-high a..g segment pattern.
// Ports:
//   nibble  in   4  hex value 0..F
//   glyph   out  7  segments a..g on bits 0..6
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] glyph
);

  always_comb begin
    glyph = hex_glyph(nibble);
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// rtl/seg7_scan_ctrl.sv - multiplexed 7-segment scan controller with tear-free commit and PWM
// Purpose: holds one hex nibble per digit in shadow registers, copies them to
//   the live set at each frame start, and scans the digits with a blank gap
//   and 4-bit PWM brightness. Optional leading-zero blanking: SEG7_LZB_EN.
// Ports:
//   clk         in   1           system clock
//   rst_n       in   1           asynchronous active-low reset
//   ena         in   1           scan enable; low forces dark outputs and idle
//   wr_valid    in   1           nibble write request
//   wr_ready    out  1           low only in the commit cycle
//   wr_digit    in   DW          target digit (out-of-range writes are dropped)
//   wr_value    in   4           hex value
//   brightness  in   4           PWM duty in 1/16 of the show window
//   seg_out     out  7           segments a..g, active-high
//   dig_sel     out  NUM_DIGITS  one-hot digit enable, active-high
//   frame_tick  out  1           pulse on each commit cycle
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int SLOT_CYC   = 1024,
  parameter int BLANK_CYC  = 16,
  localparam int DW        = $clog2(NUM_DIGITS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ena,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [DW-1:0]         wr_digit,
  input  logic [3:0]            wr_value,
  input  logic [3:0]            brightness,
  output logic [6:0]            seg_out,
  output logic [NUM_DIGITS-1:0] dig_sel,
  output logic                  frame_tick
);

  localparam int CW = $clog2(SLOT_CYC);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);
  localparam logic [CW-1:0] SLOT_LAST  = CW'(SLOT_CYC - 1);
  localparam logic [CW-1:0] BLANK_OFS  = CW'(BLANK_CYC);
  localparam logic [DW-1:0] LAST_DIGIT = DW'(NUM_DIGITS - 1);
  localparam logic [DW:0]   NUM_DIG_W  = (DW + 1)'(NUM_DIGITS);

  seg7_state_e           state_q, state_d;
  logic [CW-1:0]         slot_cnt_q, slot_cnt_d;
  logic [DW-1:0]         digit_idx_q, digit_idx_d;
  logic [3:0]            shadow_q [NUM_DIGITS];
  logic [3:0]            shadow_d [NUM_DIGITS];
  logic [3:0]            live_q   [NUM_DIGITS];
  logic [3:0]            live_d   [NUM_DIGITS];
  logic [6:0]            seg_out_q, seg_out_d;
  logic [NUM_DIGITS-1:0] dig_sel_q, dig_sel_d;

  logic                  commit_now;
  logic                  wr_fire;
  logic [CW-1:0]         pwm_phase;
  logic                  pwm_on;
  logic                  digit_dark;
  logic [3:0]            cur_nibble;
  logic [6:0]            cur_glyph;

  // A commit that is interrupted by ena falling does not happen, so the
  // handshake stall and the tick follow the same qualified condition.
  assign commit_now = ena && (state_q == COMMIT);
  assign wr_ready   = !commit_now;
  assign wr_fire    = wr_valid && wr_ready;
  assign frame_tick = commit_now;

  // Outputs are registered, but ena low darkens them in the same cycle.
  assign seg_out = ena ? seg_out_q : '0;
  assign dig_sel = ena ? dig_sel_q : '0;

  assign cur_nibble = live_q[digit_idx_q];
  assign pwm_phase  = slot_cnt_q - BLANK_OFS;
  assign pwm_on     = pwm_phase[3:0] < brightness;

  seg7_hex_decode u_decode (
    .nibble (cur_nibble),
    .glyph  (cur_glyph)
  );

`ifdef SEG7_LZB_EN
  logic [NUM_DIGITS-1:0] blank_mask_q, blank_mask_d;

  // Scan from the most significant digit down; a digit is dark while every
  // digit at or above it is zero. Digit 0 always shows.
  always_comb begin
    logic zero_run;
    zero_run     = 1'b1;
    blank_mask_d = blank_mask_q;
    if (commit_now) begin
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
        zero_run        = zero_run && (shadow_q[i] == 4'h0);
        blank_mask_d[i] = (i != 0) && zero_run;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blank_mask_q <= '0;
    end else begin
      blank_mask_q <= blank_mask_d;
    end
  end

  assign digit_dark = blank_mask_q[digit_idx_q];
`else
  assign digit_dark = 1'b0;
`endif

  always_comb begin
    shadow_d = shadow_q;
    if (wr_fire && ({1'b0, wr_digit} < NUM_DIG_W)) begin
      shadow_d[wr_digit] = wr_value;
    end
  end

  always_comb begin
    state_d     = state_q;
    slot_cnt_d  = slot_cnt_q;
    digit_idx_d = digit_idx_q;
    live_d      = live_q;
    seg_out_d   = '0;
    dig_sel_d   = '0;
    if (!ena) begin
      state_d     = IDLE;
      slot_cnt_d  = '0;
      digit_idx_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d = COMMIT;
        end
        COMMIT: begin
          live_d      = shadow_q;
          state_d     = BLANK;
          slot_cnt_d  = '0;
          digit_idx_d = '0;
        end
        BLANK: begin
          slot_cnt_d = slot_cnt_q + 1'b1;
          if (slot_cnt_q == BLANK_LAST) begin
            state_d = SHOW;
          end
        end
        SHOW: begin
          dig_sel_d = NUM_DIGITS'(1) << digit_idx_q;
          if (pwm_on && !digit_dark) begin
            seg_out_d = cur_glyph;
          end
          if (slot_cnt_q == SLOT_LAST) begin
            slot_cnt_d = '0;
            if (digit_idx_q != LAST_DIGIT) begin
              digit_idx_d = digit_idx_q + 1'b1;
              state_d     = BLANK;
            end else begin
              state_d = COMMIT;
            end
          end else begin
            slot_cnt_d = slot_cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      slot_cnt_q  <= '0;
      digit_idx_q <= '0;
      seg_out_q   <= '0;
      dig_sel_q   <= '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        shadow_q[i] <= '0;
        live_q[i]   <= '0;
      end
    end else begin
      state_q     <= state_d;
      slot_cnt_q  <= slot_cnt_d;
      digit_idx_q <= digit_idx_d;
      seg_out_q   <= seg_out_d;
      dig_sel_q   <= dig_sel_d;
      shadow_q    <= shadow_d;
      live_q      <= live_d;
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb/tb_seg7_scan_ctrl.sv - directed self-checking bench for seg7_scan_ctrl
module tb_seg7_scan_ctrl;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic       wr_valid;
  logic       wr_ready;
  logic [1:0] wr_digit;
  logic [3:0] wr_value;
  logic [3:0] brightness;
  logic [6:0] seg_out;
  logic [3:0] dig_sel;
  logic       frame_tick;

  int tests_run    = 0;
  int tests_failed = 0;

`ifdef SEG7_LZB_EN
  localparam logic [6:0] ZG = 7'h00;
`else
  localparam logic [6:0] ZG = 7'h3F;
`endif

  seg7_scan_ctrl #(
    .NUM_DIGITS (4),
    .SLOT_CYC   (64),
    .BLANK_CYC  (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_digit   (wr_digit),
    .wr_value   (wr_value),
    .brightness (brightness),
    .seg_out    (seg_out),
    .dig_sel    (dig_sel),
    .frame_tick (frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_write(input logic [1:0] d, input logic [3:0] v);
    int n;
    n = 0;
    @(negedge clk);
    wr_valid = 1'b1;
    wr_digit = d;
    wr_value = v;
    while (!wr_ready && n < 4) begin
      @(negedge clk);
      n++;
    end
    check("wr_accept", wr_ready, 1);
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  task automatic wait_tick();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_tick && n < 600);
    check("tick_seen", frame_tick, 1);
  endtask

  // Called on the negedge where frame_tick is high (offset 0); returns on the
  // negedge of the following frame_tick (offset 257). Output at offset o
  // reflects slot cycle c = (o-2) % 64 of digit (o-2) / 64.
  task automatic scan_frame(input string tag,
                            input logic [6:0] g0, input logic [6:0] g1,
                            input logic [6:0] g2, input logic [6:0] g3,
                            input logic [3:0] br, input int wr_at, input logic [3:0] wr_val,
                            output int lit0, output int lit_all,
                            output logic [6:0] seg_s, output logic [15:0] dig_s);
    logic [6:0] gl [4];
    int derr, serr, terr, k, c;
    logic [3:0] exp_d;
    logic [6:0] exp_s;
    gl[0] = g0; gl[1] = g1; gl[2] = g2; gl[3] = g3;
    derr = 0; serr = 0; terr = 0; lit0 = 0; lit_all = 0;
    seg_s = '0; dig_s = '0;
    for (int o = 1; o <= 257; o++) begin
      @(negedge clk);
      if (o == wr_at) begin
        wr_valid = 1'b1;
        wr_digit = 2'd0;
        wr_value = wr_val;
      end else begin
        wr_valid = 1'b0;
      end
      exp_d = '0;
      exp_s = '0;
      k = -1;
      if (o >= 2) begin
        k = (o - 2) / 64;
        c = (o - 2) % 64;
        if (c >= 8) begin
          exp_d = 4'(1) << k;
          if (((c - 8) % 16) < int'(br)) exp_s = gl[k];
        end
      end
      if (dig_sel !== exp_d) derr++;
      if (seg_out !== exp_s) serr++;
      if (frame_tick !== (o == 257)) terr++;
      if (seg_out != 7'h00) begin
        lit_all++;
        if (k == 0) lit0++;
      end
      if (o == 10)  begin seg_s = seg_out; dig_s[3:0] = dig_sel; end
      if (o == 74)  dig_s[7:4]   = dig_sel;
      if (o == 138) dig_s[11:8]  = dig_sel;
      if (o == 202) dig_s[15:12] = dig_sel;
    end
    wr_valid = 1'b0;
    check({tag, "_dig_errs"}, derr, 0);
    check({tag, "_seg_errs"}, serr, 0);
    check({tag, "_tick_errs"}, terr, 0);
  endtask

  int          lit0, lita, acc, nrdy0, tick_hs;
  logic [6:0]  segs;
  logic [15:0] digs;
  logic        drv, rdy;
  logic [3:0]  hs_vals [4];

  initial begin
    rst_n      = 1'b0;
    ena        = 1'b0;
    wr_valid   = 1'b0;
    wr_digit   = 2'd0;
    wr_value   = 4'd0;
    brightness = 4'd15;

    repeat (3) @(negedge clk);
    check("rst_seg", seg_out, 0);
    check("rst_dig", dig_sel, 0);
    check("rst_tick", frame_tick, 0);
    check("rst_ready", wr_ready, 1);
    rst_n = 1'b1;

    // Load 1,2,3,4 while idle, then start scanning.
    do_write(2'd0, 4'h1);
    do_write(2'd1, 4'h2);
    do_write(2'd2, 4'h3);
    do_write(2'd3, 4'h4);
    @(negedge clk);
    check("t1_tick_idle", frame_tick, 0);
    ena = 1'b1;
    @(negedge clk);
    check("t1_tick_first", frame_tick, 1);

    scan_frame("t2", 7'h06, 7'h5B, 7'h4F, 7'h66, 4'd15, -1, 4'h0, lit0, lita, segs, digs);
    check("t2_seg_d0", segs, 7'h06);
    check("t2_dig_seq", digs, 16'h8421);

    // Mid-frame write must not disturb the frame in progress.
    scan_frame("t3a", 7'h06, 7'h5B, 7'h4F, 7'h66, 4'd15, 100, 4'h8, lit0, lita, segs, digs);
    check("t3a_seg_old", segs, 7'h06);
    scan_frame("t3b", 7'h7F, 7'h5B, 7'h4F, 7'h66, 4'd15, -1, 4'h0, lit0, lita, segs, digs);
    check("t3b_seg_new", segs, 7'h7F);

    // Stream 9,A,B,C to digit 1 across the commit cycle.
    hs_vals[0] = 4'h9; hs_vals[1] = 4'hA; hs_vals[2] = 4'hB; hs_vals[3] = 4'hC;
    acc = 0; nrdy0 = 0; tick_hs = 0; drv = 1'b0; rdy = 1'b0;
    repeat (253) @(negedge clk);
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      if (frame_tick) tick_hs++;
      if (drv && rdy) acc++;
      if (acc < 4) begin
        wr_valid = 1'b1;
        wr_digit = 2'd1;
        wr_value = hs_vals[acc];
        drv = 1'b1;
        rdy = wr_ready;
        if (!wr_ready) nrdy0++;
      end else begin
        wr_valid = 1'b0;
        drv = 1'b0;
        rdy = 1'b0;
      end
    end
    check("t4_accepted", acc, 4);
    check("t4_stall_cycles", nrdy0, 1);
    check("t4_tick_once", tick_hs, 1);
    repeat (70) @(negedge clk);
    check("t4_last_show_write_seg", seg_out, 7'h7C);
    check("t4_last_show_write_dig", dig_sel, 4'b0010);
    wait_tick();
    scan_frame("t4", 7'h7F, 7'h39, 7'h4F, 7'h66, 4'd15, -1, 4'h0, lit0, lita, segs, digs);
    check("t4_seg_d0", segs, 7'h7F);

    brightness = 4'd4;
    scan_frame("t5a", 7'h7F, 7'h39, 7'h4F, 7'h66, 4'd4, -1, 4'h0, lit0, lita, segs, digs);
    check("t5_lit_d0_b4", lit0, 16);
    check("t5_lit_all_b4", lita, 64);
    brightness = 4'd0;
    scan_frame("t5b", 7'h7F, 7'h39, 7'h4F, 7'h66, 4'd0, -1, 4'h0, lit0, lita, segs, digs);
    check("t5_lit_all_b0", lita, 0);

    // ena low mid-SHOW: dark immediately, shadow retained.
    brightness = 4'd15;
    repeat (100) @(negedge clk);
    check("ena_pre_dig", dig_sel, 4'b0010);
    check("ena_pre_seg", seg_out, 7'h39);
    ena = 1'b0;
    #1;
    check("ena_off_seg", seg_out, 0);
    check("ena_off_dig", dig_sel, 0);
    @(negedge clk);
    check("ena_off_ready", wr_ready, 1);
    check("ena_off_tick", frame_tick, 0);
    ena = 1'b1;
    @(negedge clk);
    check("ena_on_tick", frame_tick, 1);
    scan_frame("ena_resume", 7'h7F, 7'h39, 7'h4F, 7'h66, 4'd15, -1, 4'h0, lit0, lita, segs, digs);

    // Asynchronous reset mid-SHOW.
    repeat (100) @(negedge clk);
    check("t1_pre_dig", dig_sel, 4'b0010);
    #2;
    rst_n = 1'b0;
    #1;
    check("t1_async_seg", seg_out, 0);
    check("t1_async_dig", dig_sel, 0);
    @(negedge clk);
    ena = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("t1_post_tick_idle", frame_tick, 0);
    ena = 1'b1;
    @(negedge clk);
    check("t1_post_tick", frame_tick, 1);
    scan_frame("t1_zero", 7'h3F, ZG, ZG, ZG, 4'd15, -1, 4'h0, lit0, lita, segs, digs);
    check("t1_zero_seg_d0", segs, 7'h3F);

`ifdef SEG7_LZB_EN
    do_write(2'd3, 4'h0);
    do_write(2'd2, 4'h0);
    do_write(2'd1, 4'h4);
    do_write(2'd0, 4'h2);
    wait_tick();
    scan_frame("t6", 7'h5B, 7'h66, 7'h00, 7'h00, 4'd15, -1, 4'h0, lit0, lita, segs, digs);
    check("t6_seg_d0", segs, 7'h5B);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
